// File: rtl/msb_norm_shift.sv
// Left-normalises a word using its 1-based MSB position so the leading one sits in bit N-1.
// Multi-cycle shifter (8-bit or 1-bit steps) with valid/ready on both sides.
module msb_norm_shift #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [7:0]   in_pos,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_mant,
  output logic [7:0]   out_exp,
  output logic         out_zero,
  output logic         out_err,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [8:0] N9 = 9'(N);
  localparam logic [7:0] N8 = 8'(N);

  state_t         state_p0;
  logic [N-1:0]   shreg_p0;
  logic [7:0]     cnt_p0;
  logic [7:0]     exp_p0;
  logic           zero_p0;
  logic           err_p0;
  logic           vld_p0;

  logic [7:0]     acc_cnt;
  logic [7:0]     acc_exp;
  logic           acc_zero;
  logic           acc_err;

  // Remaining shift after one step: coarse byte steps first, then single bits.
  function automatic logic [7:0] next_cnt(input logic [7:0] c);
    return (c >= 8'd8) ? (c - 8'd8) : (c - 8'd1);
  endfunction

  function automatic logic [N-1:0] next_shreg(input logic [N-1:0] v, input logic [7:0] c);
    return (c >= 8'd8) ? (v << 8) : (v << 1);
  endfunction

  // Accept-time decode of the MSB position.
  always_comb begin
    acc_cnt  = 8'd0;
    acc_exp  = 8'd0;
    acc_zero = 1'b0;
    acc_err  = 1'b0;
    if (in_pos == 8'd0) begin
      acc_zero = 1'b1;
    end else if ({1'b0, in_pos} > N9) begin
      acc_err = 1'b1;
    end else begin
      acc_cnt = N8 - in_pos;
      acc_exp = in_pos - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= IDLE;
      shreg_p0 <= '0;
      cnt_p0   <= 8'd0;
      exp_p0   <= 8'd0;
      zero_p0  <= 1'b0;
      err_p0   <= 1'b0;
      vld_p0   <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (in_valid) begin
            shreg_p0 <= in_data;
            cnt_p0   <= acc_cnt;
            exp_p0   <= acc_exp;
            zero_p0  <= acc_zero;
            err_p0   <= acc_err;
            state_p0 <= (acc_cnt == 8'd0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          shreg_p0 <= next_shreg(shreg_p0, cnt_p0);
          cnt_p0   <= next_cnt(cnt_p0);
          if (next_cnt(cnt_p0) == 8'd0)
            state_p0 <= DONE;
        end
        DONE: begin
          // Result is presented one cycle after entering DONE, then held until taken.
          if (!vld_p0) begin
            vld_p0 <= 1'b1;
          end else if (out_ready) begin
            vld_p0   <= 1'b0;
            state_p0 <= IDLE;
          end
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_p0 == IDLE) & ~rst;
  assign busy      = (state_p0 != IDLE);
  assign out_valid = vld_p0;
  assign out_mant  = shreg_p0;
  assign out_exp   = exp_p0;
  assign out_zero  = zero_p0;
  assign out_err   = err_p0;

endmodule

// File: tb/tb_msb_norm_shift.sv
// Directed bench for msb_norm_shift (N=32): latency, normalised results,
// back-pressure stability, range error, zero word and mid-operation reset.
module tb_msb_norm_shift;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [7:0]   in_pos;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_mant;
  logic [7:0]   out_exp;
  logic         out_zero;
  logic         out_err;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  msb_norm_shift #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_pos    (in_pos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_zero  (out_zero),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one word, measure latency, check result, optionally stall, then handshake.
  task automatic run_op(input string tag, input logic [N-1:0] d, input logic [7:0] p,
                        input int stall, input logic [N-1:0] em, input logic [7:0] ee,
                        input logic ez, input logic eer, input int elat);
    int  lat;
    logic got;
    chk({tag, "_rdy_idle"}, 64'(in_ready), 64'd1);
    in_data   = d;
    in_pos    = p;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      got = out_valid;
    end
    chk({tag, "_lat"},  64'(lat),      64'(elat));
    chk({tag, "_mant"}, 64'(out_mant), 64'(em));
    chk({tag, "_exp"},  64'(out_exp),  64'(ee));
    chk({tag, "_zero"}, 64'(out_zero), 64'(ez));
    chk({tag, "_err"},  64'(out_err),  64'(eer));
    chk({tag, "_rdy_busy"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_data  = ~d;
      in_pos   = 8'd1;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_stall_vld"},  64'(out_valid), 64'd1);
      chk({tag, "_stall_mant"}, 64'(out_mant),  64'(em));
      chk({tag, "_stall_exp"},  64'(out_exp),   64'(ee));
      chk({tag, "_stall_rdy"},  64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_hs_vld"},  64'(out_valid), 64'd0);
    chk({tag, "_hs_busy"}, 64'(busy),      64'd0);
    chk({tag, "_hs_rdy"},  64'(in_ready),  64'd1);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_pos    = 8'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld",  64'(out_valid), 64'd0);
    chk("rst_mant", 64'(out_mant),  64'd0);
    chk("rst_exp",  64'(out_exp),   64'd0);
    chk("rst_zero", 64'(out_zero),  64'd0);
    chk("rst_err",  64'(out_err),   64'd0);
    chk("rst_rdy",  64'(in_ready),  64'd0);
    chk("rst_busy", 64'(busy),      64'd0);
    rst = 1'b0;
    @(negedge clk);

    //      tag   data          pos   stall mant          exp    z     e     lat
    run_op("c1", 32'h0000_0001, 8'd1,  0, 32'h8000_0000, 8'd0,  1'b0, 1'b0, 11);
    run_op("c2", 32'h0000_00A5, 8'd8,  0, 32'hA500_0000, 8'd7,  1'b0, 1'b0, 4);
    run_op("c3", 32'h8000_0000, 8'd32, 0, 32'h8000_0000, 8'd31, 1'b0, 1'b0, 1);
    run_op("c4", 32'h0000_0000, 8'd0,  0, 32'h0000_0000, 8'd0,  1'b1, 1'b0, 1);
    run_op("c5", 32'h0000_0001, 8'd1,  5, 32'h8000_0000, 8'd0,  1'b0, 1'b0, 11);
    run_op("c6", 32'h1234_5678, 8'd40, 0, 32'h1234_5678, 8'd0,  1'b0, 1'b1, 1);
    run_op("c7", 32'h000F_1234, 8'd20, 0, 32'hF123_4000, 8'd19, 1'b0, 1'b0, 6);

    // Reset during SHIFT aborts the operation.
    in_data  = 32'h0000_0001;
    in_pos   = 8'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("ab_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("ab_busy_rst", 64'(busy),      64'd0);
    chk("ab_rdy_rst",  64'(in_ready),  64'd0);
    chk("ab_mant_rst", 64'(out_mant),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ab_rdy_after", 64'(in_ready), 64'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("ab_no_result", 64'(seen), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
